elixirchip_es1_spu_regfile: RTL
===============================

# elixirchip_es1_spu_regfile

Small flop-based register file that feeds operand pairs to the ES1 SPU two-input op units (`*_spu_op_*`) and accepts their `m_data` results as write-back. One write port and two read ports. Read data is delivered with a fixed, `cke`-qualified latency, and `s_clear`/`s_valid` sideband is pipelined alongside so the outputs connect directly to an op unit's `s_data0`/`s_data1`/`s_clear`/`s_valid`.

## Interface
- `REG_NUM`, 16, number of registers (2..64)
- `ADDR_BITS`, `$clog2(REG_NUM)`, address width
- `DATA_BITS`, 8, data width
- `data_t`, `logic [DATA_BITS-1:0]`, data type
- `INIT_DATA`, 0, reset value of every register; also the read value for out-of-range addresses
- `READ_LATENCY`, 1, read latency in `cke` cycles (1..3)
- `DEVICE`, "RTL", target device string
- `SIMULATION`, "false", simulation mode
- `DEBUG`, "false", debug mode
- `reset` in 1: synchronous, active-high
- `clk` in 1: clock
- `cke` in 1: clock enable; when 0 all state holds
- `s_wr_en` in 1: write enable
- `s_wr_addr` in ADDR_BITS: write address
- `s_wr_data` in DATA_BITS: write data
- `s_rd_addr0` in ADDR_BITS: read address, port 0
- `s_rd_addr1` in ADDR_BITS: read address, port 1
- `s_rd_clear` in 1: clear sideband, pipelined to `m_clear`
- `s_rd_valid` in 1: valid sideband, pipelined to `m_valid`
- `m_data0` out DATA_BITS: read data, port 0
- `m_data1` out DATA_BITS: read data, port 1
- `m_clear` out 1: delayed `s_rd_clear`
- `m_valid` out 1: delayed `s_rd_valid`

## Operation
- Storage is REG_NUM flops of `data_t`.
  - `reset` sets every register to INIT_DATA.
  - `reset` clears every pipeline stage: data stages to INIT_DATA, clear/valid stages to 0.
- Write: on a posedge with `cke && s_wr_en && s_wr_addr < REG_NUM`, the register at `s_wr_addr` takes `s_wr_data`. A write to an address >= REG_NUM is ignored.
- Read: on a posedge with `cke`, stage 1 captures `reg[s_rd_addrN]`, or INIT_DATA if the address is >= REG_NUM. Stages 2..READ_LATENCY shift on `cke`.
- Read data is a snapshot taken at stage 1. A write that lands after the capture does not alter data already in flight.
- Both ports are independent and may read the same address.
- `s_rd_clear` and `s_rd_valid` ride the same stages as the data. No gating is applied: `m_data` updates regardless of `s_rd_valid`.
- `cke`=0: writes are ignored, and every stage and every output holds its value.
- `reset` has priority over `cke` and over a write in the same cycle.
- `reset` mid-operation discards all in-flight reads. `m_valid` is 0 from the cycle after the reset edge.

## Timing
- Address and sideband sampled at cke-edge N appear on `m_*` after cke-edge N+READ_LATENCY-1. With READ_LATENCY=1 they are valid in the cycle following edge N.
- Only `cke`=1 edges count toward latency.
- Reset values of the outputs: `m_data0` = `m_data1` = INIT_DATA, `m_clear` = 0, `m_valid` = 0.
- Read and write to the same address at the same edge: behaviour is set by the Configuration macro below.
- Write-to-read turnaround with no bypass: data written at edge N is readable by an address sampled at edge N+1.

## Configuration
- Macro: `ELIXIRCHIP_ES1_SPU_REGFILE_BYPASS_EN`.
- Defined: a same-edge read of the write address captures `s_wr_data` (write-first forwarding), per port.
- Undefined: a same-edge read captures the old register value (read-first). This saves the forwarding mux.

## Test plan
- Reset, then read all addresses with REG_NUM=16, INIT_DATA=8'h5a, READ_LATENCY=1 -> `m_data0`/`m_data1` = 8'h5a throughout; `m_valid`=0 until the first `s_rd_valid`=1.
- Write 8'h3c to reg 3, next cycle read addr0=3 and addr1=3 with `s_rd_valid`=1, READ_LATENCY=3 -> both ports show 8'h3c exactly 3 cke cycles later, with `m_valid`=1 aligned.
- Reg 7 holds 8'h11; write 8'hee to reg 7 and read addr0=7 at the same edge -> 8'hee with the macro defined, 8'h11 without.
- Issue reads with `s_rd_clear`=1 on the 2nd read, and drop `cke` for 2 cycles mid-stream -> outputs freeze during `cke`=0; `m_clear` appears on exactly the 2nd result; latency counts only `cke`=1 edges.
- With REG_NUM=12: write 8'h77 to addr 13, then read addr 13 and addr 12 -> both return INIT_DATA; regs 0..11 are unchanged.
- Assert `reset` while 3 valid reads are in flight (READ_LATENCY=3) -> `m_valid`=0 on the next cycle and stays 0 until new reads propagate; all registers return INIT_DATA.

Source files
------------

// File: rtl/elixirchip_es1_spu_regfile.sv
// rtl/elixirchip_es1_spu_regfile.sv - flop register file, 1 write / 2 read ports, cke-qualified read pipeline
// Optional write-first forwarding: ELIXIRCHIP_ES1_SPU_REGFILE_BYPASS_EN

module elixirchip_es1_spu_regfile #(
    parameter int    REG_NUM      = 16,
    parameter int    ADDR_BITS    = $clog2(REG_NUM),
    parameter int    DATA_BITS    = 8,
    parameter type   data_t       = logic [DATA_BITS-1:0],
    parameter data_t INIT_DATA    = '0,
    parameter int    READ_LATENCY = 1,
    parameter string DEVICE       = "RTL",
    parameter string SIMULATION   = "false",
    parameter string DEBUG        = "false"
) (
    input  logic                 reset,
    input  logic                 clk,
    input  logic                 cke,

    input  logic                 s_wr_en,
    input  logic [ADDR_BITS-1:0] s_wr_addr,
    input  data_t                s_wr_data,

    input  logic [ADDR_BITS-1:0] s_rd_addr0,
    input  logic [ADDR_BITS-1:0] s_rd_addr1,
    input  logic                 s_rd_clear,
    input  logic                 s_rd_valid,

    output data_t                m_data0,
    output data_t                m_data1,
    output logic                 m_clear,
    output logic                 m_valid
);

    data_t regs [REG_NUM];

    data_t data0_pipe [READ_LATENCY];
    data_t data1_pipe [READ_LATENCY];
    logic  clear_pipe [READ_LATENCY];
    logic  valid_pipe [READ_LATENCY];

    logic  wr_ok;
    data_t rd_data0;
    data_t rd_data1;

    assign wr_ok = s_wr_en && (int'(s_wr_addr) < REG_NUM);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= INIT_DATA;
            end
        end else if (cke && wr_ok) begin
            regs[s_wr_addr] <= s_wr_data;
        end
    end

    // Out-of-range read addresses return INIT_DATA, matching the reset image.
    always_comb begin
        rd_data0 = INIT_DATA;
        rd_data1 = INIT_DATA;
        if (int'(s_rd_addr0) < REG_NUM) begin
            rd_data0 = regs[s_rd_addr0];
        end
        if (int'(s_rd_addr1) < REG_NUM) begin
            rd_data1 = regs[s_rd_addr1];
        end
`ifdef ELIXIRCHIP_ES1_SPU_REGFILE_BYPASS_EN
        if (wr_ok && s_wr_addr == s_rd_addr0) begin
            rd_data0 = s_wr_data;
        end
        if (wr_ok && s_wr_addr == s_rd_addr1) begin
            rd_data1 = s_wr_data;
        end
`endif
    end

    // Stage 0 snapshots the register file; later writes never reach data in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                data0_pipe[i] <= INIT_DATA;
                data1_pipe[i] <= INIT_DATA;
                clear_pipe[i] <= 1'b0;
                valid_pipe[i] <= 1'b0;
            end
        end else if (cke) begin
            data0_pipe[0] <= rd_data0;
            data1_pipe[0] <= rd_data1;
            clear_pipe[0] <= s_rd_clear;
            valid_pipe[0] <= s_rd_valid;
            for (int i = 1; i < READ_LATENCY; i++) begin
                data0_pipe[i] <= data0_pipe[i-1];
                data1_pipe[i] <= data1_pipe[i-1];
                clear_pipe[i] <= clear_pipe[i-1];
                valid_pipe[i] <= valid_pipe[i-1];
            end
        end
    end

    assign m_data0 = data0_pipe[READ_LATENCY-1];
    assign m_data1 = data1_pipe[READ_LATENCY-1];
    assign m_clear = clear_pipe[READ_LATENCY-1];
    assign m_valid = valid_pipe[READ_LATENCY-1];

endmodule
